// File: rtl/acc_bank.sv
// Multi-channel memory-mapped add/sub accumulator with saturating counters and sticky overflow; ACC_THRESH_EN adds THRESH/HIT/irq.
// Latency: writes land at the next posedge clk, reads are combinational and return pre-write state.
// Backpressure: none, every ce&&we access is accepted in the cycle it is presented.
module acc_bank #(
  parameter int NCH = 4,
  parameter int DW  = 32,
  parameter int CW  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        we,
  input  logic [6:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [4:0] NCH5 = 5'(NCH);

  logic [3:0]  ch;
  logic [2:0]  rsel;
  logic        ch_ok;
  logic        wr_en;
  logic [31:0] ch_rd [NCH];

  assign ch    = addr[6:3];
  assign rsel  = addr[2:0];
  assign ch_ok = ({1'b0, ch} < NCH5);
  assign wr_en = ce && we && ch_ok;

`ifdef ACC_THRESH_EN
  logic [NCH-1:0] hit_vec;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          sub;
    logic          sat;
    logic          ovf;
    logic          hit;
    logic [DW-1:0] sum;
    logic [DW-1:0] acc_nxt;
    logic          ov;
    logic [31:0]   rd_val;
    logic          sel;

    assign sel = wr_en && (ch == 4'(i));

    // Saturation direction follows the sign of ACC: overflow can only push
    // away from it, so a non-negative ACC clamps to +max and a negative to -min.
    always_comb begin
      sum = sub ? (acc - wdata[DW-1:0]) : (acc + wdata[DW-1:0]);
      if (sub)
        ov = (acc[DW-1] != wdata[DW-1]) && (sum[DW-1] != acc[DW-1]);
      else
        ov = (acc[DW-1] == wdata[DW-1]) && (sum[DW-1] != acc[DW-1]);
      acc_nxt = sum;
      if (ov && sat)
        acc_nxt = acc[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc <= '0;
        cnt <= '0;
        sub <= 1'b0;
        sat <= 1'b0;
        ovf <= 1'b0;
      end else if (sel) begin
        case (rsel)
          3'd0: begin
            acc <= acc_nxt;
            if (cnt != '1) cnt <= cnt + CW'(1);
            if (ov) ovf <= 1'b1;
          end
          3'd1: begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end
          3'd2: begin
            sub <= wdata[0];
            sat <= wdata[1];
          end
          3'd3: if (wdata[0]) ovf <= 1'b0;
          default: ;
        endcase
      end
    end

`ifdef ACC_THRESH_EN
    logic [DW-1:0] thresh;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        thresh <= '0;
        hit    <= 1'b0;
      end else if (sel) begin
        case (rsel)
          3'd0: if ($signed(acc_nxt) >= $signed(thresh)) hit <= 1'b1;
          3'd1: hit <= 1'b0;
          3'd3: if (wdata[1]) hit <= 1'b0;
          3'd4: thresh <= wdata[DW-1:0];
          default: ;
        endcase
      end
    end

    assign hit_vec[i] = hit;
`else
    assign hit = 1'b0;
`endif

    always_comb begin
      rd_val = '0;
      case (rsel)
        3'd0: rd_val = 32'(acc);
        3'd1: rd_val = 32'(cnt);
        3'd2: rd_val = {30'd0, sat, sub};
        3'd3: rd_val = {30'd0, hit, ovf};
`ifdef ACC_THRESH_EN
        3'd4: rd_val = 32'(thresh);
`endif
        default: rd_val = '0;
      endcase
    end

    assign ch_rd[i] = rd_val;
  end

  always_comb begin
    rdata = '0;
    if (ce && !reset && ch_ok) begin
      for (int i = 0; i < NCH; i++)
        if (ch == 4'(i)) rdata = ch_rd[i];
    end
  end

`ifdef ACC_THRESH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= |hit_vec;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_acc_bank.sv
// Directed bench for acc_bank (NCH=4, DW=32, CW=2 so counter saturation is reachable).
module tb_acc_bank;
  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        we;
  logic [6:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int fails  = 0;

  acc_bank #(.NCH(4), .DW(32), .CW(2)) dut (
    .clk(clk), .reset(reset), .ce(ce), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int c, input int r, input logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = {4'(c), 3'(r)}; wdata = d;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int c, input int r, input logic [31:0] exp);
    ce = 1'b1; we = 1'b0; addr = {4'(c), 3'(r)};
    #1;
    chk(tag, rdata, exp);
    ce = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("rst_acc0", 0, 0, 32'd0);
    rd_chk("rst_cnt2", 2, 1, 32'd0);

    // basic accumulation and counter saturation at 3 (CW=2)
    wr(0, 0, 32'd5); wr(0, 0, 32'd7); wr(0, 0, 32'd100);
    rd_chk("t1_acc", 0, 0, 32'd112);
    rd_chk("t1_cnt", 0, 1, 32'd3);
    rd_chk("t1_ovf", 0, 3, 32'd0);
    rd_chk("t1_ch1", 1, 0, 32'd0);
    rd_chk("t1_ch3", 3, 0, 32'd0);
    wr(0, 0, 32'd1);
    rd_chk("cnt_sat_acc", 0, 0, 32'd113);
    rd_chk("cnt_sat_cnt", 0, 1, 32'd3);

    // subtract mode
    wr(1, 2, 32'd1); wr(1, 0, 32'd10);
    rd_chk("t2_ctrl", 1, 2, 32'd1);
    rd_chk("t2_acc", 1, 0, 32'hFFFF_FFF6);
    rd_chk("t2_cnt", 1, 1, 32'd1);
    rd_chk("t2_ovf", 1, 3, 32'd0);

    // overflow wrap vs saturate
    wr(2, 0, 32'h7FFF_FFFF); wr(2, 0, 32'd1);
    rd_chk("t3_wrap_acc", 2, 0, 32'h8000_0000);
    rd_chk("t3_wrap_ovf", 2, 3, 32'd1);
    wr(3, 2, 32'd2); wr(3, 0, 32'h7FFF_FFFF); wr(3, 0, 32'd1);
    rd_chk("t3_sat_acc", 3, 0, 32'h7FFF_FFFF);
    rd_chk("t3_sat_ovf", 3, 3, 32'd1);
    wr(3, 3, 32'd1);
    rd_chk("t3_w1c", 3, 3, 32'd0);
    rd_chk("t3_w1c_acc", 3, 0, 32'h7FFF_FFFF);
    wr(2, 0, 32'hFFFF_FFFF);
    rd_chk("t3_negwrap_acc", 2, 0, 32'h7FFF_FFFF);
    // SUB+SAT: 0 - 0x80000000 overflows positive and clamps to +max
    wr(3, 1, 32'd0); wr(3, 2, 32'd3); wr(3, 0, 32'h8000_0000);
    rd_chk("t3_subsat_acc", 3, 0, 32'h7FFF_FFFF);
    rd_chk("t3_subsat_ovf", 3, 3, 32'd1);

    // clear via CNT write, out-of-range channel, ce gating
    wr(0, 1, 32'hDEAD_BEEF);
    rd_chk("t4_acc", 0, 0, 32'd0);
    rd_chk("t4_cnt", 0, 1, 32'd0);
    rd_chk("t4_ovf", 0, 3, 32'd0);
    wr(5, 0, 32'd99);
    rd_chk("t4_ch5_rd", 5, 0, 32'd0);
    rd_chk("t4_ch5_ch0", 0, 0, 32'd0);
    rd_chk("t4_ch5_ch1", 1, 0, 32'hFFFF_FFF6);
    rd_chk("t4_ch5_cnt1", 1, 1, 32'd1);
    @(negedge clk);
    ce = 1'b0; we = 1'b1; addr = {4'd1, 3'd0}; wdata = 32'd1;
    #1;
    chk("t4_ce0_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    we = 1'b0;
    rd_chk("t4_ce0_acc", 1, 0, 32'hFFFF_FFF6);
    rd_chk("t4_ce0_cnt", 1, 1, 32'd1);
    rd_chk("rsvd_reg", 1, 6, 32'd0);

    // read during write returns the pre-write value
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = {4'd0, 3'd0}; wdata = 32'd9;
    #1;
    chk("rdw_pre", rdata, 32'd0);
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0;
    rd_chk("rdw_post", 0, 0, 32'd9);

    // reset landing on an in-flight write
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = {4'd0, 3'd0}; wdata = 32'd6;
    #2 reset = 1'b1;
    #1;
    chk("t5_rdata_rst", rdata, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0; ce = 1'b0; we = 1'b0;
    #1;
    rd_chk("t5_acc0", 0, 0, 32'd0);
    rd_chk("t5_acc1", 1, 0, 32'd0);
    rd_chk("t5_ctrl3", 3, 2, 32'd0);
    rd_chk("t5_ovf2", 2, 3, 32'd0);
    chk("t5_irq", {31'd0, irq}, 32'd0);

`ifdef ACC_THRESH_EN
    wr(1, 4, 32'd50);
    rd_chk("t6_thresh", 1, 4, 32'd50);
    wr(1, 0, 32'd30);
    rd_chk("t6_hit0", 1, 3, 32'd0);
    @(posedge clk); #1;
    chk("t6_irq0", {31'd0, irq}, 32'd0);
    wr(1, 0, 32'd30);
    rd_chk("t6_hit1", 1, 3, 32'd2);
    @(posedge clk); #1;
    chk("t6_irq1", {31'd0, irq}, 32'd1);
    wr(1, 3, 32'd2);
    @(posedge clk); #1;
    chk("t6_irq_clr", {31'd0, irq}, 32'd0);
    rd_chk("t6_hit_clr", 1, 3, 32'd0);
`else
    wr(1, 4, 32'd50);
    rd_chk("t6_nothresh", 1, 4, 32'd0);
    wr(1, 0, 32'd60);
    rd_chk("t6_nohit", 1, 3, 32'd0);
    @(posedge clk); #1;
    chk("t6_noirq", {31'd0, irq}, 32'd0);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
